// File: rtl/connect_pkg.sv
// Shared constants and helpers for the round-robin say->heard connector.
package connect_pkg;

  // Scheduler rule index of the respond rule inside rule_enable / rule_ready.
  localparam int RESPOND_RULE = 0;

  // Channel id width: clog2 of the channel count, never narrower than one bit.
  function automatic int chan_w(input int num_chan);
    return (num_chan <= 2) ? 1 : $clog2(num_chan);
  endfunction

endpackage

// File: rtl/connect_rr_fifo_if.sv
// Request/indication bundle between the request demux, the connector and the
// indication pipe. master = environment side, slave = connector side.
interface connect_rr_fifo_if #(
  parameter int NUM_CHAN = 4,
  parameter int DATA_W   = 32,
  parameter int CHAN_W   = 2,
  parameter int CNT_W    = 3
);
  logic [NUM_CHAN-1:0]        say__ENA;
  logic [NUM_CHAN*DATA_W-1:0] say_meth;
  logic [NUM_CHAN*DATA_W-1:0] say_v;
  logic [NUM_CHAN-1:0]        say__RDY;

  logic                       ind_heard__ENA;
  logic [DATA_W-1:0]          ind_heard_heard_meth;
  logic [DATA_W-1:0]          ind_heard_heard_v;
  logic [CHAN_W-1:0]          ind_heard_heard_chan;
  logic                       ind_heard__RDY;

  logic [0:0]                 rule_enable;
  logic [0:0]                 rule_ready;
  logic [CNT_W-1:0]           fifo_count;
  logic [31:0]                heard_total;

  modport master (
    output say__ENA, say_meth, say_v, ind_heard__RDY, rule_enable,
    input  say__RDY, ind_heard__ENA, ind_heard_heard_meth, ind_heard_heard_v,
           ind_heard_heard_chan, rule_ready, fifo_count, heard_total
  );

  modport slave (
    input  say__ENA, say_meth, say_v, ind_heard__RDY, rule_enable,
    output say__RDY, ind_heard__ENA, ind_heard_heard_meth, ind_heard_heard_v,
           ind_heard_heard_chan, rule_ready, fifo_count, heard_total
  );
endinterface

// File: rtl/sync_fifo_n.sv
// Synchronous FIFO with combinational head read, occupancy count and
// full/empty flags. DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo_n #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enq,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_deq,
  output logic [WIDTH-1:0] o_first,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_enq;
  logic             w_do_deq;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_do_enq = i_enq && !o_full;
  assign w_do_deq = i_deq && !o_empty;
  assign o_first  = r_mem[r_rd_ptr];
  assign o_count  = r_count;

  // Storage write at the write pointer.
  // NOTE: the data array has no reset; its contents are only observed when
  // count>0, so clearing it would cost logic for no behavioural gain.
  always_ff @(posedge clk) begin
    if (w_do_enq) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointer and occupancy bookkeeping with synchronous active-low reset.
  // NOTE: sequential state always uses non-blocking assignment so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CNT_W'(w_do_enq) - CNT_W'(w_do_deq);
    end
  end

endmodule

// File: rtl/connect_rr_fifo.sv
// Multi-channel say->heard connector: time-slot round-robin acceptance of
// say requests into a channel-tagged FIFO, drained by the respond rule.
module connect_rr_fifo
  import connect_pkg::*;
#(
  parameter int NUM_CHAN = 4,
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int CHAN_W   = chan_w(NUM_CHAN)
) (
  input  logic             CLK,
  input  logic             nRST,
  connect_rr_fifo_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [DATA_W-1:0] meth;
    logic [DATA_W-1:0] v;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [CHAN_W-1:0]   r_slot;
  logic [31:0]         r_heard_total;

  logic [NUM_CHAN-1:0] w_say_rdy;
  logic [DATA_W-1:0]   w_sel_meth;
  logic [DATA_W-1:0]   w_sel_v;
  logic                w_enq;
  logic                w_deq;
  logic                w_respond_rdy;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [CNT_W-1:0]    w_count_next;
  entry_t              w_din;
  entry_t              w_head;
  logic [ENTRY_W-1:0]  w_first;

  // Ready guard and payload mux for the channel owning the current slot.
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_say_rdy  = '0;
    w_sel_meth = '0;
    w_sel_v    = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (r_slot == CHAN_W'(i)) begin
        w_say_rdy[i] = !w_full;
        w_sel_meth   = bus.say_meth[i*DATA_W +: DATA_W];
        w_sel_v      = bus.say_v[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_enq         = |(bus.say__ENA & w_say_rdy);
  assign w_respond_rdy = !w_empty && bus.ind_heard__RDY;
  assign w_deq         = bus.rule_enable[RESPOND_RULE] && w_respond_rdy;
  assign w_count_next  = w_count + CNT_W'(w_enq) - CNT_W'(w_deq);

  assign w_din  = '{chan: r_slot, meth: w_sel_meth, v: w_sel_v};
  assign w_head = entry_t'(w_first);

  sync_fifo_n #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (nRST),
    .i_enq   (w_enq),
    .i_din   (w_din),
    .i_deq   (w_deq),
    .o_first (w_first),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Slot steps every cycle unless the FIFO will be full after this edge.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_slot <= '0;
    end else if (w_count_next < CNT_W'(DEPTH)) begin
      if (r_slot == CHAN_W'(NUM_CHAN - 1)) r_slot <= '0;
      else                                 r_slot <= r_slot + CHAN_W'(1);
    end
  end

  // Count of fired indications, free-running modulo 2^32.
  always_ff @(posedge CLK) begin
    if (!nRST)      r_heard_total <= '0;
    else if (w_deq) r_heard_total <= r_heard_total + 32'd1;
  end

  assign bus.say__RDY             = w_say_rdy;
  assign bus.ind_heard__ENA       = w_deq;
  assign bus.ind_heard_heard_meth = w_head.meth;
  assign bus.ind_heard_heard_v    = w_head.v;
  assign bus.ind_heard_heard_chan = w_head.chan;
  assign bus.rule_ready[RESPOND_RULE] = w_respond_rdy;
  assign bus.fifo_count           = w_count;
  assign bus.heard_total          = r_heard_total;

endmodule

// File: tb/tb_connect_rr_fifo.sv
// Testbench for connect_rr_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based model of the connector.
module tb_connect_rr_fifo;

  localparam int NUM_CHAN = 4;
  localparam int DEPTH    = 4;
  localparam int DATA_W   = 32;
  localparam int CHAN_W   = 2;
  localparam int CNT_W    = 3;

  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  connect_rr_fifo_if #(
    .NUM_CHAN (NUM_CHAN), .DATA_W (DATA_W), .CHAN_W (CHAN_W), .CNT_W (CNT_W)
  ) bus ();

  connect_rr_fifo #(
    .NUM_CHAN (NUM_CHAN), .DEPTH (DEPTH), .DATA_W (DATA_W), .CHAN_W (CHAN_W)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  // Reference model: a queue of accepted entries plus slot and total.
  typedef struct {
    int          chan;
    logic [31:0] meth;
    logic [31:0] v;
  } ent_t;

  ent_t        m_q[$];
  int          m_slot;
  logic [31:0] m_total;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [NUM_CHAN-1:0] exp_rdy();
    logic [NUM_CHAN-1:0] r = '0;
    if (m_q.size() < DEPTH) r[m_slot] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_rule_ready();
    return (m_q.size() > 0) && bus.ind_heard__RDY;
  endfunction

  function automatic logic exp_fire();
    return exp_rule_ready() && bus.rule_enable[0];
  endfunction

  // Apply the connector's rules to the inputs present at this clock edge.
  function automatic void model_update();
    bit   accept, fire;
    ent_t e;
    if (!nRST) begin
      m_q.delete();
      m_slot  = 0;
      m_total = '0;
      return;
    end
    accept = (m_q.size() < DEPTH) && bus.say__ENA[m_slot];
    fire   = exp_fire();
    if (fire) begin
      e = m_q.pop_front();
      m_total = m_total + 32'd1;
    end
    if (accept) begin
      e.chan = m_slot;
      e.meth = bus.say_meth[m_slot*DATA_W +: DATA_W];
      e.v    = bus.say_v[m_slot*DATA_W +: DATA_W];
      m_q.push_back(e);
    end
    if (m_q.size() < DEPTH) m_slot = (m_slot + 1) % NUM_CHAN;
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic drive(input logic [NUM_CHAN-1:0] ena, input logic ind_rdy,
                       input logic rule_en);
    bus.say__ENA       = ena;
    bus.ind_heard__RDY = ind_rdy;
    bus.rule_enable    = rule_en;
  endtask

  task automatic set_payloads(input logic [31:0] meth_base, input logic [31:0] v_base);
    for (int i = 0; i < NUM_CHAN; i++) begin
      bus.say_meth[i*DATA_W +: DATA_W] = meth_base + 32'(i);
      bus.say_v[i*DATA_W +: DATA_W]    = v_base + 32'(i);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    drive('0, 1'b0, 1'b0);
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if (bus.say__RDY !== 4'b0001) begin
      n_fail++; $display("FAIL reset_rdy: got %b expected 0001", bus.say__RDY);
    end
    n_tests++;
    if (bus.rule_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_rule_ready: got %b expected 0", bus.rule_ready);
    end
    n_tests++;
    if (bus.fifo_count !== '0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count);
    end
    n_tests++;
    if (bus.heard_total !== 32'd0) begin
      n_fail++; $display("FAIL reset_total: got %0d expected 0", bus.heard_total);
    end
    tick();
  endtask

  task automatic test_idle_rotation();
    logic [NUM_CHAN-1:0] want;
    do_reset();
    drive('0, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      #1;
      want = 4'b0001 << (c % NUM_CHAN);
      n_tests++;
      if (bus.say__RDY !== want) begin
        n_fail++; $display("FAIL idle_rdy cyc %0d: got %b expected %b", c, bus.say__RDY, want);
      end
      n_tests++;
      if (bus.rule_ready !== 1'b0 || bus.fifo_count !== '0) begin
        n_fail++; $display("FAIL idle_empty cyc %0d: got rr=%b cnt=%0d expected rr=0 cnt=0",
                           c, bus.rule_ready, bus.fifo_count);
      end
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    set_payloads(32'h0, 32'h0);
    bus.say_meth[2*DATA_W +: DATA_W] = 32'h11;
    bus.say_v[2*DATA_W +: DATA_W]    = 32'h22;
    drive(4'b0100, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++;
      if (bus.ind_heard__ENA !== (c == 3) || bus.ind_heard__ENA !== exp_fire()) begin
        n_fail++; $display("FAIL single_fire cyc %0d: got %b expected %b",
                           c, bus.ind_heard__ENA, (c == 3));
      end
      if (c == 3) begin
        n_tests++;
        if (bus.ind_heard_heard_meth !== 32'h11 || bus.ind_heard_heard_v !== 32'h22 ||
            bus.ind_heard_heard_chan !== 2'd2) begin
          n_fail++; $display("FAIL single_head: got meth=%h v=%h chan=%0d expected 11 22 2",
                             bus.ind_heard_heard_meth, bus.ind_heard_heard_v,
                             bus.ind_heard_heard_chan);
        end
        bus.say__ENA = '0;
      end
      tick();
    end
    #1;
    n_tests++;
    if (bus.heard_total !== 32'd1 || bus.fifo_count !== '0) begin
      n_fail++; $display("FAIL single_total: got total=%0d cnt=%0d expected 1 0",
                         bus.heard_total, bus.fifo_count);
    end
  endtask

  task automatic test_fill();
    do_reset();
    set_payloads(32'hA0, 32'hB0);
    drive(4'b1111, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++;
      if (bus.say__RDY !== exp_rdy()) begin
        n_fail++; $display("FAIL fill_rdy cyc %0d: got %b expected %b", c, bus.say__RDY, exp_rdy());
      end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++;
      if (bus.fifo_count !== 3'd4 || bus.say__RDY !== '0) begin
        n_fail++; $display("FAIL full_hold cyc %0d: got cnt=%0d rdy=%b expected 4 0000",
                           c, bus.fifo_count, bus.say__RDY);
      end
      n_tests++;
      if (bus.ind_heard_heard_chan !== 2'd0 || bus.ind_heard_heard_meth !== 32'hA0) begin
        n_fail++; $display("FAIL full_head: got chan=%0d meth=%h expected 0 a0",
                           bus.ind_heard_heard_chan, bus.ind_heard_heard_meth);
      end
      if (c < 3) tick();
    end
  endtask

  // Continues from the full state left by test_fill.
  task automatic test_drain();
    int guard;
    bus.ind_heard__RDY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++;
      if (bus.ind_heard__ENA !== 1'b1 || bus.ind_heard_heard_chan !== CHAN_W'(c) ||
          bus.ind_heard_heard_meth !== 32'hA0 + 32'(c)) begin
        n_fail++; $display("FAIL drain_order cyc %0d: got ena=%b chan=%0d meth=%h expected 1 %0d %h",
                           c, bus.ind_heard__ENA, bus.ind_heard_heard_chan,
                           bus.ind_heard_heard_meth, c, 32'hA0 + 32'(c));
      end
      n_tests++;
      if (bus.say__RDY !== exp_rdy() || (c == 1 && bus.say__RDY !== 4'b0001)) begin
        n_fail++; $display("FAIL drain_rdy cyc %0d: got %b expected %b", c, bus.say__RDY, exp_rdy());
      end
      n_tests++;
      if (bus.fifo_count !== CNT_W'(m_q.size())) begin
        n_fail++; $display("FAIL drain_count cyc %0d: got %0d expected %0d",
                           c, bus.fifo_count, m_q.size());
      end
      tick();
    end
    bus.say__ENA = '0;
    guard = 0;
    while (m_q.size() > 0 && guard < 10) begin
      #1;
      n_tests++;
      if (bus.ind_heard__ENA !== 1'b1 ||
          bus.ind_heard_heard_chan !== CHAN_W'(m_q[0].chan) ||
          bus.ind_heard_heard_meth !== m_q[0].meth) begin
        n_fail++; $display("FAIL drain_tail: got ena=%b chan=%0d meth=%h expected 1 %0d %h",
                           bus.ind_heard__ENA, bus.ind_heard_heard_chan,
                           bus.ind_heard_heard_meth, m_q[0].chan, m_q[0].meth);
      end
      tick();
      guard++;
    end
    #1;
    n_tests++;
    if (bus.fifo_count !== '0 || bus.heard_total !== m_total) begin
      n_fail++; $display("FAIL drain_end: got cnt=%0d total=%0d expected 0 %0d",
                         bus.fifo_count, bus.heard_total, m_total);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    do_reset();
    set_payloads(32'hC0, 32'hD0);
    drive(4'b0001, 1'b0, 1'b1);
    tick();
    drive('0, 1'b1, 1'b1);
    tick();
    drive(4'b1111, 1'b0, 1'b1);
    guard = 0;
    while (m_q.size() < 3 && guard < 10) begin
      tick();
      guard++;
    end
    #1;
    n_tests++;
    if (bus.fifo_count !== 3'd3 || bus.heard_total !== 32'd1) begin
      n_fail++; $display("FAIL mid_pre: got cnt=%0d total=%0d expected 3 1",
                         bus.fifo_count, bus.heard_total);
    end
    nRST = 1'b0;
    drive('0, 1'b1, 1'b1);
    tick();
    nRST = 1'b1;
    #1;
    n_tests++;
    if (bus.fifo_count !== '0 || bus.rule_ready !== 1'b0 || bus.say__RDY !== 4'b0001 ||
        bus.heard_total !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset: got cnt=%0d rr=%b rdy=%b total=%0d expected 0 0 0001 0",
                         bus.fifo_count, bus.rule_ready, bus.say__RDY, bus.heard_total);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    set_payloads(32'hE0, 32'hF0);
    drive(4'b0001, 1'b0, 1'b1);
    tick();
    drive('0, 1'b0, 1'b1);
    force dut.r_heard_total = 32'hFFFF_FFFF;
    #1;
    release dut.r_heard_total;
    m_total = 32'hFFFF_FFFF;
    #1;
    n_tests++;
    if (bus.heard_total !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL wrap_pre: got %h expected ffffffff", bus.heard_total);
    end
    bus.ind_heard__RDY = 1'b1;
    tick();
    #1;
    n_tests++;
    if (bus.heard_total !== 32'd0 || bus.heard_total !== m_total) begin
      n_fail++; $display("FAIL wrap_total: got %h expected 0", bus.heard_total);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      nRST = ($urandom_range(0, 63) != 0);
      drive(NUM_CHAN'($urandom) & NUM_CHAN'($urandom | $urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));
      for (int i = 0; i < NUM_CHAN; i++) begin
        bus.say_meth[i*DATA_W +: DATA_W] = $urandom;
        bus.say_v[i*DATA_W +: DATA_W]    = $urandom;
      end
      #1;
      n_tests++;
      if (bus.say__RDY !== exp_rdy()) begin
        n_fail++; $display("FAIL rand_rdy cyc %0d: got %b expected %b", c, bus.say__RDY, exp_rdy());
      end
      n_tests++;
      if (bus.rule_ready !== exp_rule_ready() || bus.ind_heard__ENA !== exp_fire()) begin
        n_fail++; $display("FAIL rand_guard cyc %0d: got rr=%b ena=%b expected %b %b",
                           c, bus.rule_ready, bus.ind_heard__ENA, exp_rule_ready(), exp_fire());
      end
      n_tests++;
      if (bus.fifo_count !== CNT_W'(m_q.size()) || bus.heard_total !== m_total) begin
        n_fail++; $display("FAIL rand_state cyc %0d: got cnt=%0d total=%0d expected %0d %0d",
                           c, bus.fifo_count, bus.heard_total, m_q.size(), m_total);
      end
      if (m_q.size() > 0) begin
        n_tests++;
        if (bus.ind_heard_heard_chan !== CHAN_W'(m_q[0].chan) ||
            bus.ind_heard_heard_meth !== m_q[0].meth || bus.ind_heard_heard_v !== m_q[0].v) begin
          n_fail++; $display("FAIL rand_head cyc %0d: got chan=%0d meth=%h v=%h expected %0d %h %h",
                             c, bus.ind_heard_heard_chan, bus.ind_heard_heard_meth,
                             bus.ind_heard_heard_v, m_q[0].chan, m_q[0].meth, m_q[0].v);
        end
      end
      tick();
    end
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    drive('0, 1'b0, 1'b0);
    set_payloads('0, '0);
    m_slot  = 0;
    m_total = '0;
    @(negedge CLK);
    test_reset();
    test_idle_rotation();
    test_single();
    test_fill();
    test_drain();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
